// File: rtl/num_convert.sv
// Integer <-> FPU-float converter: int->float normalises by left shifts, and
// float->int denormalises by right shifts with truncation and saturation.
module num_convert (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] int_in,
    input  logic        in_s,
    input  logic [6:0]  in_e,
    input  logic [14:0] in_m,
    output logic        res_s,
    output logic [6:0]  res_e,
    output logic [14:0] res_m,
    output logic [15:0] res_int,
    output logic        busy,
    output logic        done,
    output logic        zero_flag,
    output logic        overflow_flag,
    output logic        underflow_flag
);
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    localparam logic [6:0] E_ZERO = 7'b1000000;
    localparam logic [6:0] E_INF  = 7'b0111111;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [15:0] op_int_q, op_int_d;
    logic        op_s_q, op_s_d;
    logic [6:0]  op_e_q, op_e_d;
    logic [14:0] op_m_q, op_m_d;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        res_s_q, res_s_d;
    logic [6:0]  res_e_q, res_e_d;
    logic [14:0] res_m_q, res_m_d;
    logic [15:0] res_int_q, res_int_d;
    logic        zf_q, zf_d, of_q, of_d, uf_q, uf_d;
    logic [15:0] sat_val;

    assign sat_val = op_s_q ? 16'h7FFF : 16'h8000;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        op_int_d  = op_int_q;
        op_s_d    = op_s_q;
        op_e_d    = op_e_q;
        op_m_d    = op_m_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        res_s_d   = res_s_q;
        res_e_d   = res_e_q;
        res_m_d   = res_m_q;
        res_int_d = res_int_q;
        zf_d      = zf_q;
        of_d      = of_q;
        uf_d      = uf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    op_int_d = int_in;
                    op_s_d   = in_s;
                    op_e_d   = in_e;
                    op_m_d   = in_m;
                    zf_d     = 1'b0;
                    of_d     = 1'b0;
                    uf_d     = 1'b0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (!mode_q) begin
                    if (op_int_q == 16'h0000) begin
                        res_s_d = 1'b1;
                        res_e_d = E_ZERO;
                        res_m_d = 15'h4000;
                        zf_d    = 1'b1;
                    end else begin
                        // -32768 negates to itself, which is the correct magnitude
                        mag_d   = op_int_q[15] ? (~op_int_q + 16'd1) : op_int_q;
                        cnt_d   = 5'd15;
                        state_d = SHIFT;
                    end
                end else if (op_e_q == E_ZERO) begin
                    res_int_d = 16'h0000;
                    zf_d      = 1'b1;
                end else if (op_e_q == E_INF) begin
                    res_int_d = sat_val;
                    of_d      = 1'b1;
                end else if (op_e_q[6]) begin
                    res_int_d = 16'h0000;
                    zf_d      = 1'b1;
                    uf_d      = 1'b1;
                end else if (op_e_q >= 7'd15) begin
                    if (!op_s_q && op_e_q == 7'd15 && op_m_q == 15'h4000) begin
                        res_int_d = 16'h8000;
                    end else begin
                        res_int_d = sat_val;
                        of_d      = 1'b1;
                    end
                end else begin
                    mag_d   = {1'b0, op_m_q};
                    cnt_d   = 5'd14 - op_e_q[4:0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!mode_q) begin
                    if (!mag_q[15]) begin
                        mag_d = {mag_q[14:0], 1'b0};
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        res_m_d = mag_q[15:1];
                        res_e_d = {2'b00, cnt_q};
                        res_s_d = ~op_int_q[15];
                        state_d = DONE;
                    end
                end else begin
                    if (cnt_q != 5'd0) begin
                        mag_d = {1'b0, mag_q[15:1]};
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        res_int_d = op_s_q ? mag_q : (~mag_q + 16'd1);
                        state_d   = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            op_int_q  <= '0;
            op_s_q    <= 1'b0;
            op_e_q    <= '0;
            op_m_q    <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            res_s_q   <= 1'b0;
            res_e_q   <= '0;
            res_m_q   <= '0;
            res_int_q <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            op_int_q  <= op_int_d;
            op_s_q    <= op_s_d;
            op_e_q    <= op_e_d;
            op_m_q    <= op_m_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            res_s_q   <= res_s_d;
            res_e_q   <= res_e_d;
            res_m_q   <= res_m_d;
            res_int_q <= res_int_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
            uf_q      <= uf_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign res_s          = res_s_q;
    assign res_e          = res_e_q;
    assign res_m          = res_m_q;
    assign res_int        = res_int_q;
    assign zero_flag      = zf_q;
    assign overflow_flag  = of_q;
    assign underflow_flag = uf_q;
endmodule

// File: tb/tb_num_convert.sv
// Bench for num_convert: directed corner cases plus random operands, checked
// against an arithmetic reference model that tracks every result register.
module tb_num_convert;
    logic        clk = 1'b0;
    logic        reset, start, mode, in_s;
    logic [15:0] int_in;
    logic [6:0]  in_e;
    logic [14:0] in_m;
    logic        res_s, busy, done, zero_flag, overflow_flag, underflow_flag;
    logic [6:0]  res_e;
    logic [14:0] res_m;
    logic [15:0] res_int;

    num_convert dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .int_in(int_in),
        .in_s(in_s), .in_e(in_e), .in_m(in_m), .res_s(res_s), .res_e(res_e),
        .res_m(res_m), .res_int(res_int), .busy(busy), .done(done),
        .zero_flag(zero_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        e_s, e_zf, e_of, e_uf;
    logic [6:0]  e_e;
    logic [14:0] e_m;
    logic [15:0] e_int;
    int          e_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the value each encoding represents.
    task automatic model(input logic md, input logic [15:0] iv, input logic s,
                         input logic [6:0] e, input logic [14:0] m);
        int mag, p, ev, v;
        e_zf = 1'b0; e_of = 1'b0; e_uf = 1'b0;
        if (!md) begin
            if (iv == 16'h0000) begin
                e_s = 1'b1; e_e = 7'h40; e_m = 15'h4000; e_zf = 1'b1; e_lat = 1;
            end else begin
                mag = iv[15] ? 65536 - int'(iv) : int'(iv);
                p = 0;
                for (int b = 0; b < 16; b++) if (mag >= (1 << b)) p = b;
                e_s   = ~iv[15];
                e_e   = 7'(p);
                e_m   = 15'((mag << (15 - p)) >> 1);
                e_lat = (15 - p) + 2;
            end
        end else begin
            ev = e[6] ? int'(e) - 128 : int'(e);
            e_lat = 1;
            if (e == 7'h40) begin
                e_int = 16'h0000; e_zf = 1'b1;
            end else if (e == 7'h3F) begin
                e_int = s ? 16'h7FFF : 16'h8000; e_of = 1'b1;
            end else if (ev < 0) begin
                e_int = 16'h0000; e_zf = 1'b1; e_uf = 1'b1;
            end else if (ev >= 15) begin
                if (!s && ev == 15 && m == 15'h4000) e_int = 16'h8000;
                else begin
                    e_int = s ? 16'h7FFF : 16'h8000; e_of = 1'b1;
                end
            end else begin
                v     = int'(m) / (1 << (14 - ev));
                e_int = s ? 16'(v) : 16'(65536 - v);
                e_lat = (14 - ev) + 2;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".res_s"}, 32'(res_s), 32'(e_s));
        chk({tag, ".res_e"}, 32'(res_e), 32'(e_e));
        chk({tag, ".res_m"}, 32'(res_m), 32'(e_m));
        chk({tag, ".res_int"}, 32'(res_int), 32'(e_int));
        chk({tag, ".flags"}, 32'({zero_flag, overflow_flag, underflow_flag}),
            32'({e_zf, e_of, e_uf}));
    endtask

    task automatic run(input string tag, input logic md, input logic [15:0] iv,
                       input logic s, input logic [6:0] e, input logic [14:0] m,
                       input bit start_in_done);
        int lat;
        bit got;
        @(negedge clk);
        mode = md; int_in = iv; in_s = s; in_e = e; in_m = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        model(md, iv, s, e, m);
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".busy_done"}, 32'(busy), 32'd1);
        check_outputs(tag);
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".busy_clear"}, 32'(busy), 32'd0);
        if (start_in_done) begin
            @(posedge clk); #1;
            chk({tag, ".ignored_start"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; mode = 1'b0; int_in = '0;
        in_s = 1'b0; in_e = '0; in_m = '0;
        e_s = 1'b0; e_e = '0; e_m = '0; e_int = '0;
        e_zf = 1'b0; e_of = 1'b0; e_uf = 1'b0; e_lat = 0;
        #12;
        check_outputs("reset");
        chk("reset.busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk); reset = 1'b0;

        run("i2f_one",   1'b0, 16'h0001, 1'b0, 7'd0, 15'd0, 1'b0);
        run("i2f_m6",    1'b0, 16'hFFFA, 1'b0, 7'd0, 15'd0, 1'b1);
        run("i2f_min",   1'b0, 16'h8000, 1'b0, 7'd0, 15'd0, 1'b0);
        run("i2f_zero",  1'b0, 16'h0000, 1'b0, 7'd0, 15'd0, 1'b0);
        run("f2i_pos10", 1'b1, 16'h0000, 1'b1, 7'd3, 15'h5000, 1'b0);
        run("f2i_neg10", 1'b1, 16'h0000, 1'b0, 7'd3, 15'h5000, 1'b0);
        run("f2i_min",   1'b1, 16'h0000, 1'b0, 7'd15, 15'h4000, 1'b0);
        run("f2i_e15",   1'b1, 16'h0000, 1'b1, 7'd15, 15'h4000, 1'b0);
        run("f2i_inf",   1'b1, 16'h0000, 1'b0, 7'h3F, 15'h4000, 1'b0);
        run("f2i_under", 1'b1, 16'h0000, 1'b1, 7'h7F, 15'h6000, 1'b0);
        run("f2i_zero",  1'b1, 16'h0000, 1'b1, 7'h40, 15'h4000, 1'b0);

        @(negedge clk);
        mode = 1'b0; int_in = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        reset = 1'b1;
        #1;
        e_s = 1'b0; e_e = '0; e_m = '0; e_int = '0;
        e_zf = 1'b0; e_of = 1'b0; e_uf = 1'b0;
        check_outputs("abort");
        chk("abort.busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort.no_done", 32'(dones), 32'd0);
        run("i2f_four", 1'b0, 16'h0004, 1'b0, 7'd0, 15'd0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic md;
            logic [15:0] iv;
            logic [6:0] ev;
            md = 1'($urandom);
            iv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) iv = 16'($urandom) >> $urandom_range(0, 15);
            ev = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 16)) : 7'($urandom);
            run("rand", md, iv, 1'($urandom), ev, {1'b1, 14'($urandom)}, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
